// File: rtl/jtkcpu_busresp.sv
// Bus responder for the JTKCPU 24-bit byte bus.
// Converts a chip-selected CPU access into a req/ack memory transaction,
// answers repeated reads from a one-entry cache and raises dtack after
// a programmable number of cen-counted wait states.
module jtkcpu_busresp #(
  parameter int WAIT_MIN = 1,
  parameter bit CACHE_EN = 1'b1,
  parameter int TOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cs,
  input  logic [23:0] addr,
  input  logic        we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        dtack,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;

  // Last tolerated REQ cycle and the wait-state target, both 8-bit counters
  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MIN);
  localparam bit         NO_WAIT   = (WAIT_MIN == 0);

  state_t      state_q;
  logic [23:0] a_addr_q;
  logic        a_we_q;
  logic [7:0]  a_data_q;
  logic        c_valid_q;
  logic [23:0] c_addr_q;
  logic [7:0]  c_data_q;
  logic [7:0]  tout_q;
  logic [7:0]  tout_d;
  logic [7:0]  wcnt_q;
  logic [7:0]  wcnt_d;
  logic        drop_q;
  logic        hit;
  logic        expired;

  logic [7:0]  cpu_din_q;
  logic        dtack_q;
  logic        mem_req_q;
  logic [23:0] mem_addr_q;
  logic        mem_we_q;
  logic [7:0]  mem_wdata_q;
  logic        err_q;

  assign cpu_din   = cpu_din_q;
  assign dtack     = dtack_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Cache lookup for the incoming access and the counter increments
  always_comb begin
    hit     = CACHE_EN && !we && c_valid_q && (addr == c_addr_q);
    tout_d  = tout_q + 8'd1;
    wcnt_d  = wcnt_q + 8'd1;
    expired = (tout_q == TOUT_LAST);
  end

  // Access sequencer: latch, request/cache, wait states, dtack hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_addr_q    <= '0;
      a_we_q      <= 1'b0;
      a_data_q    <= '0;
      c_valid_q   <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      tout_q      <= '0;
      wcnt_q      <= '0;
      drop_q      <= 1'b0;
      cpu_din_q   <= '0;
      dtack_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs) begin
            a_addr_q <= addr;
            a_we_q   <= we;
            a_data_q <= cpu_dout;
            wcnt_q   <= '0;
            drop_q   <= 1'b0;
            if (hit) begin
              cpu_din_q <= c_data_q;
              if (NO_WAIT) begin
                dtack_q <= 1'b1;
                state_q <= ST_HOLD;
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              mem_req_q   <= 1'b1;
              mem_addr_q  <= addr;
              mem_we_q    <= we;
              mem_wdata_q <= cpu_dout;
              tout_q      <= '0;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (!cs) drop_q <= 1'b1;
          if (mem_ack || expired) begin
            mem_req_q <= 1'b0;
            if (mem_ack) begin
              if (!a_we_q) begin
                cpu_din_q <= mem_rdata;
                c_addr_q  <= a_addr_q;
                c_data_q  <= mem_rdata;
                c_valid_q <= 1'b1;
              end else if (c_valid_q && (a_addr_q == c_addr_q)) begin
                c_data_q <= a_data_q;
              end
            end else begin
              cpu_din_q <= 8'hFF;
              err_q     <= 1'b1;
              c_valid_q <= 1'b0;
            end
            if (drop_q || !cs) begin
              state_q <= ST_IDLE;
            end else if (NO_WAIT) begin
              dtack_q <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            tout_q <= tout_d;
          end
        end
        ST_WAIT: begin
          if (!cs) begin
            state_q <= ST_IDLE;
          end else if (cen) begin
            if (wcnt_d == WAIT_LAST) begin
              dtack_q <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              wcnt_q <= wcnt_d;
            end
          end
        end
        ST_HOLD: begin
          if (!cs || (addr != a_addr_q) || (we != a_we_q)) begin
            dtack_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Self-checking bench for jtkcpu_busresp.
// A transaction-level model predicts, from the latency rules, the cycle
// windows where mem_req and dtack must be high, the data the CPU must see
// and the sticky error flag; a negedge process compares every cycle.
module tb_jtkcpu_busresp;

  localparam int WAIT_MIN = 1;
  localparam int TOUT     = 255;
  localparam int NEVER    = 1000000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        cs;
  logic [23:0] addr;
  logic        we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        dtack;
  logic        mem_req;
  logic        mem_ack;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        err;

  jtkcpu_busresp #(.WAIT_MIN(WAIT_MIN), .CACHE_EN(1'b1), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .addr(addr), .we(we),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack(dtack), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  // Free-running clock and a cycle index counted in rising edges
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Transaction model: expected windows and values for the current access
  bit          tActive = 1'b0;
  int          reqStart, reqEnd, readyCyc, dropCyc, errCyc;
  bit          errOn = 1'b0;
  logic [7:0]  expData;
  logic [23:0] expAddr;
  logic        expWe;
  logic [7:0]  expWdata;
  int          pulses = 0;
  int          reqHighCount = 0;
  int          dtackRise = -1;
  int          ackAt = -1;

  // Cache and CPU-visible data model
  bit          cValid = 1'b0;
  logic [23:0] cAddr = '0;
  logic [7:0]  cData = '0;
  logic [7:0]  dinModel = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack = (cyc == ackAt);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start an access in the current cycle and predict its outcome.
  // ackDelay < 0 means the memory never answers.
  task automatic applyStimulus(input logic [23:0] a, input logic w, input logic [7:0] d,
                               input int ackDelay, input logic [7:0] rdata);
    int p;
    bit isHit;
    p         = cyc;
    cs        = 1'b1;
    addr      = a;
    we        = w;
    cpu_dout  = d;
    mem_rdata = rdata;
    isHit     = !w && cValid && (a == cAddr);
    pulses       = 0;
    reqHighCount = 0;
    dtackRise    = -1;
    dropCyc      = NEVER;
    ackAt        = -1;
    expAddr      = a;
    expWe        = w;
    expWdata     = d;
    if (isHit) begin
      reqStart = p + 1;
      reqEnd   = p + 1;
      readyCyc = p + 1;
      dinModel = cData;
    end else if (ackDelay >= 0 && ackDelay < TOUT) begin
      reqStart = p + 1;
      ackAt    = p + 1 + ackDelay;
      reqEnd   = ackAt + 1;
      readyCyc = ackAt + 1;
      if (!w) begin
        dinModel = rdata;
        cValid   = 1'b1;
        cAddr    = a;
        cData    = rdata;
      end else if (cValid && cAddr == a) begin
        cData = d;
      end
    end else begin
      reqStart = p + 1;
      reqEnd   = p + 1 + TOUT;
      readyCyc = reqEnd;
      dinModel = 8'hFF;
      cValid   = 1'b0;
      if (!errOn) errCyc = reqEnd;
      errOn = 1'b1;
    end
    expData = dinModel;
    tActive = 1'b1;
  endtask

  task automatic endAccess();
    cs      = 1'b0;
    dropCyc = cyc;
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    logic eReq, eDtack, eErr;
    if (!rst_n) begin
      eReq = 1'b0; eDtack = 1'b0; eErr = 1'b0;
      checkOutput("reset_cpu_din", 32'(cpu_din), 32'h0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);
    end else begin
      eReq   = tActive && cyc >= reqStart && cyc < reqEnd;
      eDtack = tActive && cyc >= readyCyc && pulses >= WAIT_MIN && cyc <= dropCyc;
      eErr   = errOn && cyc >= errCyc;
    end
    checkOutput("mem_req", 32'(mem_req), 32'(eReq));
    checkOutput("dtack", 32'(dtack), 32'(eDtack));
    checkOutput("err", 32'(err), 32'(eErr));
    if (eReq) begin
      checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
      checkOutput("mem_we", 32'(mem_we), 32'(expWe));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(expWdata));
    end
    if (eDtack) checkOutput("cpu_din", 32'(cpu_din), 32'(expData));
    if (mem_req) reqHighCount++;
    if (dtack && dtackRise < 0) dtackRise = cyc;
    if (tActive && cyc >= readyCyc && cen) pulses++;
  end

  int p;

  initial begin
    rst_n = 1'b0; cen = 1'b1; cs = 1'b0; addr = '0; we = 1'b0;
    cpu_dout = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    checkOutput("rst_dtack", 32'(dtack), 32'h0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_cpu_din", 32'(cpu_din), 32'h0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] read miss at 012345");
    applyStimulus(24'h01_2345, 1'b0, 8'h00, 3, 8'h5A);
    waitCycles(7);
    checkOutput("t1_req_cycles", 32'(reqHighCount), 32'd4);
    checkOutput("t1_ack_to_dtack", 32'(dtackRise - ackAt), 32'd2);
    checkOutput("t1_cpu_din", 32'(cpu_din), 32'h5A);
    endAccess();
    waitCycles(2);

    $display("[TB] repeat read hits the cache");
    p = cyc;
    applyStimulus(24'h01_2345, 1'b0, 8'h00, 3, 8'h00);
    waitCycles(3);
    checkOutput("t2_req_cycles", 32'(reqHighCount), 32'd0);
    checkOutput("t2_cs_to_dtack", 32'(dtackRise - p), 32'd2);
    checkOutput("t2_cpu_din", 32'(cpu_din), 32'h5A);
    endAccess();
    waitCycles(2);

    $display("[TB] write-through then read hit");
    applyStimulus(24'h01_2345, 1'b1, 8'hC3, 2, 8'h00);
    tick();
    checkOutput("t3_mem_req", 32'(mem_req), 32'h1);
    checkOutput("t3_mem_we", 32'(mem_we), 32'h1);
    checkOutput("t3_mem_wdata", 32'(mem_wdata), 32'hC3);
    waitCycles(6);
    endAccess();
    waitCycles(2);
    applyStimulus(24'h01_2345, 1'b0, 8'h00, 3, 8'h00);
    waitCycles(3);
    checkOutput("t4_req_cycles", 32'(reqHighCount), 32'd0);
    checkOutput("t4_cpu_din", 32'(cpu_din), 32'hC3);
    endAccess();
    waitCycles(2);

    $display("[TB] immediate ack, then hit with stalled cen");
    applyStimulus(24'h0A_BCDE, 1'b0, 8'h00, 0, 8'h11);
    waitCycles(5);
    checkOutput("t5_req_cycles", 32'(reqHighCount), 32'd1);
    endAccess();
    waitCycles(2);
    p = cyc;
    applyStimulus(24'h0A_BCDE, 1'b0, 8'h00, 3, 8'h00);
    cen = 1'b0;
    waitCycles(3);
    cen = 1'b1;
    waitCycles(2);
    checkOutput("t6_cs_to_dtack", 32'(dtackRise - p), 32'd4);
    checkOutput("t6_cpu_din", 32'(cpu_din), 32'h11);
    endAccess();
    waitCycles(2);

    $display("[TB] memory never answers");
    applyStimulus(24'h00_FF00, 1'b0, 8'h00, -1, 8'h00);
    waitCycles(260);
    checkOutput("t7_req_cycles", 32'(reqHighCount), 32'd255);
    checkOutput("t7_cpu_din", 32'(cpu_din), 32'hFF);
    checkOutput("t7_dtack", 32'(dtack), 32'h1);
    checkOutput("t7_err", 32'(err), 32'h1);
    ackAt = cyc + 1;
    mem_rdata = 8'h77;
    waitCycles(3);
    checkOutput("t7_late_dtack", 32'(dtack), 32'h1);
    checkOutput("t7_late_cpu_din", 32'(cpu_din), 32'hFF);
    endAccess();
    waitCycles(2);

    $display("[TB] cs dropped during request");
    applyStimulus(24'h00_0777, 1'b0, 8'h00, 4, 8'h9C);
    tick();
    endAccess();
    waitCycles(8);
    checkOutput("t8_no_dtack", 32'(dtackRise), 32'hFFFF_FFFF);
    checkOutput("t8_req_cycles", 32'(reqHighCount), 32'd5);
    waitCycles(2);
    applyStimulus(24'h00_0777, 1'b0, 8'h00, 3, 8'h00);
    waitCycles(3);
    checkOutput("t8_hit_req_cycles", 32'(reqHighCount), 32'd0);
    checkOutput("t8_hit_cpu_din", 32'(cpu_din), 32'h9C);
    endAccess();
    waitCycles(2);

    $display("[TB] reset during request");
    applyStimulus(24'h33_3333, 1'b0, 8'h00, -1, 8'h00);
    waitCycles(2);
    rst_n = 1'b0; cs = 1'b0;
    tActive = 1'b0; errOn = 1'b0; cValid = 1'b0; dinModel = 8'h00; ackAt = -1;
    #1;
    checkOutput("t9_mem_req", 32'(mem_req), 32'h0);
    checkOutput("t9_err", 32'(err), 32'h0);
    checkOutput("t9_cpu_din", 32'(cpu_din), 32'h0);
    checkOutput("t9_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    rst_n = 1'b1;
    waitCycles(2);
    applyStimulus(24'h00_0777, 1'b0, 8'h00, 2, 8'h9C);
    waitCycles(7);
    checkOutput("t9_miss_req_cycles", 32'(reqHighCount), 32'd3);
    checkOutput("t9_cpu_din_after", 32'(cpu_din), 32'h9C);
    endAccess();
    waitCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
